// File: rtl/vin_quadencoderz_filt.sv
// Quadrature encoder interface with per-channel glitch filter, X1/X2/X4 decode,
// signed position counter, index capture and one-shot index zeroing.
module vin_quadencoderz_filt #(
   parameter int WIDTH  = 32,
   parameter int FILTER = 3,
   parameter int MODE   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             quadA,
   input  logic             quadB,
   input  logic             quadZ,
   input  logic             index_arm,
   output logic             index_done,
   input  logic             err_clr,
   output logic [WIDTH-1:0] pos,
   output logic [WIDTH-1:0] index_pos,
   output logic             dir,
   output logic             err
);

   typedef enum logic [1:0] {IDLE, ARMED, DONE} idxState_e;

   // Decoding stays masked until the synchroniser and filter pipeline has
   // flushed whatever levels the encoder held while reset was asserted.
   localparam int SETTLE = 3 + FILTER;

   logic [2:0]       meta_q, sync_q, filt, prev_q;
   logic [4:0]       warm_q;
   logic             decodeEn;
   logic             aChg, bChg, illegal, stepA, stepB, zRise;
   logic             countEn, countUp, zeroLoad;
   logic [WIDTH-1:0] pos_q, pos_d, indexPos_q;
   logic             dir_q, err_q;
   idxState_e        state_q, state_d;

   // Channel order in the 3-bit vectors is {Z, B, A}.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= {quadZ, quadB, quadA};
         sync_q <= meta_q;
      end
   end

   generate
      if (FILTER == 0) begin : gBypass
         assign filt = sync_q;
      end else begin : gFilter
         for (genvar g = 0; g < 3; g++) begin : gChan
            logic [3:0] cnt_q;
            logic       filt_q;
            always_ff @(posedge clk) begin
               if (reset) begin
                  cnt_q  <= '0;
                  filt_q <= 1'b0;
               end else if (sync_q[g] != filt_q) begin
                  if (cnt_q == 4'(FILTER - 1)) begin
                     filt_q <= sync_q[g];
                     cnt_q  <= '0;
                  end else begin
                     cnt_q <= cnt_q + 4'd1;
                  end
               end else begin
                  cnt_q <= '0;
               end
            end
            assign filt[g] = filt_q;
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q <= '0;
         warm_q <= '0;
      end else begin
         prev_q <= filt;
         if (!decodeEn) warm_q <= warm_q + 5'd1;
      end
   end

   assign decodeEn = (warm_q == 5'(SETTLE));
   assign aChg     = prev_q[0] ^ filt[0];
   assign bChg     = prev_q[1] ^ filt[1];
   assign illegal  = decodeEn & aChg & bChg;
   assign stepA    = decodeEn & aChg & ~bChg;
   assign stepB    = decodeEn & bChg & ~aChg;
   assign zRise    = decodeEn & ~prev_q[2] & filt[2];

   // An A edge counts up when the new A differs from B; a B edge when they match.
   always_comb begin
      countEn = 1'b0;
      countUp = 1'b0;
      if (stepA && (MODE != 1 || filt[0])) begin
         countEn = 1'b1;
         countUp = filt[0] ^ filt[1];
      end else if (stepB && MODE == 4) begin
         countEn = 1'b1;
         countUp = ~(filt[0] ^ filt[1]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (index_arm) state_d = ARMED;
         ARMED:   if (!index_arm) state_d = IDLE;
                  else if (zRise) state_d = DONE;
         DONE:    if (!index_arm) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      index_done = (state_q == DONE);
      zeroLoad   = (state_q == ARMED) && index_arm && zRise;
   end

   always_comb begin
      pos_d = pos_q;
      if (zeroLoad)     pos_d = '0;
      else if (countEn) pos_d = countUp ? pos_q + WIDTH'(1) : pos_q - WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pos_q      <= '0;
         indexPos_q <= '0;
         dir_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         pos_q <= pos_d;
         if (zRise)   indexPos_q <= pos_q;
         if (countEn) dir_q <= countUp;
         if (illegal)      err_q <= 1'b1;
         else if (err_clr) err_q <= 1'b0;
      end
   end

   assign pos       = pos_q;
   assign index_pos = indexPos_q;
   assign dir       = dir_q;
   assign err       = err_q;

endmodule
